// File: rtl/mem_bus_sequencer.sv
// Bus sequencer for the 3-stage fetch/execute/commit core: arbitrates the shared
// address/data bus, stretches each transaction by WAIT_CYCLES and drives the
// pipeline-register enables/clears. A registered HALTED state waits for resume.
module mem_bus_sequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 6,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_store,
  input  logic              mem_load,
  input  logic              mem_store_commit,
  input  logic              store_upper,
  input  logic              is_branch_ex,
  input  logic              fetch_is_halt,
  input  logic              commit_is_halt,
  input  logic              resume,
  output logic              pc_enable,
  output logic              FE_reg_enable,
  output logic              FE_reg_clear,
  output logic              EC_reg_enable,
  output logic              EC_reg_clear,
  output logic              write_commit,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_bus_out,
  output logic              halted,
  output logic              busy
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StRun, StHold, StHalted} state_e;
  typedef enum logic [1:0] {KindStc, KindExm, KindFet} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] bus_q, bus_d;
  logic              rw_q, rw_d;

  kind_e             live_kind;
  logic [ADDR_W-1:0] live_bus;
  logic              live_rw;
  logic              live_branch;

  // Decode the request the RUN state would serve this cycle (halt handled separately).
  always_comb begin
    live_kind   = KindFet;
    live_bus    = pc;
    live_rw     = 1'b1;
    live_branch = 1'b0;
    if (mem_store_commit) begin
      live_kind            = KindStc;
      live_bus             = '0;
      live_bus[DATA_W-1:0] = mem_write_data;
      live_bus[DATA_W]     = store_upper;
      live_rw              = 1'b0;
    end else if (mem_store || mem_load) begin
      live_kind = KindExm;
      live_bus  = mem_address;
      live_rw   = ~mem_store;
    end else if (is_branch_ex) begin
      live_branch = 1'b1;
      live_bus    = '0;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      kind_q  <= KindFet;
      cnt_q   <= '0;
      bus_q   <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      rw_q    <= rw_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    logic  fin;
    kind_e fin_kind;

    state_d        = state_q;
    kind_d         = kind_q;
    cnt_d          = cnt_q;
    bus_d          = bus_q;
    rw_d           = rw_q;
    pc_enable      = 1'b0;
    FE_reg_enable  = 1'b0;
    FE_reg_clear   = 1'b0;
    EC_reg_enable  = 1'b0;
    EC_reg_clear   = 1'b0;
    write_commit   = 1'b0;
    mem_read_write = 1'b1;
    mem_bus_out    = '0;
    halted         = 1'b0;
    busy           = 1'b0;
    fin            = 1'b0;
    fin_kind       = live_kind;

    unique case (state_q)
      StRun: begin
        if (commit_is_halt) begin
          write_commit = 1'b1;
          state_d      = StHalted;
        end else if (live_branch) begin
          FE_reg_clear  = 1'b1;
          EC_reg_enable = 1'b1;
        end else begin
          mem_bus_out    = live_bus;
          mem_read_write = live_rw;
          if (WAIT_CYCLES == 0) begin
            fin = 1'b1;
          end else begin
            kind_d  = live_kind;
            bus_d   = live_bus;
            rw_d    = live_rw;
            cnt_d   = CntW'(WAIT_CYCLES);
            state_d = StHold;
          end
        end
      end
      StHold: begin
        busy           = 1'b1;
        mem_bus_out    = bus_q;
        mem_read_write = rw_q;
        fin_kind       = kind_q;
        if (cnt_q == CntW'(1)) begin
          fin     = 1'b1;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHalted: begin
        halted       = 1'b1;
        write_commit = 1'b1;
        if (resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    // Completion strobes for the last cycle of a bus transaction.
    if (fin) begin
      unique case (fin_kind)
        KindStc: begin
          write_commit = 1'b1;
          EC_reg_clear = 1'b1;
        end
        KindExm: begin
          FE_reg_clear  = 1'b1;
          EC_reg_enable = 1'b1;
        end
        default: begin
          FE_reg_enable = 1'b1;
          EC_reg_enable = 1'b1;
          pc_enable     = ~fetch_is_halt;
        end
      endcase
    end

    // Outputs go quiet for as long as reset is held, not just from the next edge.
    if (!rst_n) begin
      pc_enable      = 1'b0;
      FE_reg_enable  = 1'b0;
      FE_reg_clear   = 1'b0;
      EC_reg_enable  = 1'b0;
      EC_reg_clear   = 1'b0;
      write_commit   = 1'b0;
      mem_read_write = 1'b1;
      mem_bus_out    = '0;
      halted         = 1'b0;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: three instances (0, 2 and 3 wait states) share
// inputs and are compared every cycle against a transaction-level model.
module tb_mem_bus_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 6;
  localparam int NI = 3;
  localparam int WAITS [NI] = '{0, 2, 3};

  // Model kinds / modes.
  localparam int KStc = 0, KExm = 1, KFet = 2, KBr = 3;
  localparam int MRun = 0, MHalt = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc, mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_store, mem_load, mem_store_commit, store_upper;
  logic          is_branch_ex, fetch_is_halt, commit_is_halt, resume;

  logic [NI-1:0] pc_en, fe_en, fe_clr, ec_en, ec_clr, wc, rw, hl, bs;
  logic [AW-1:0] bus_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: mode, remaining held cycles, and the captured transaction.
  int            mode [NI], rem [NI], kind [NI];
  logic [AW-1:0] lbus [NI];
  logic          lrw  [NI];
  int            n_mode [NI], n_rem [NI], n_kind [NI];
  logic [AW-1:0] n_lbus [NI];
  logic          n_lrw  [NI];

  always #5 clk = ~clk;

  mem_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_store(mem_store), .mem_load(mem_load),
    .mem_store_commit(mem_store_commit), .store_upper(store_upper),
    .is_branch_ex(is_branch_ex), .fetch_is_halt(fetch_is_halt),
    .commit_is_halt(commit_is_halt), .resume(resume),
    .pc_enable(pc_en[0]), .FE_reg_enable(fe_en[0]), .FE_reg_clear(fe_clr[0]),
    .EC_reg_enable(ec_en[0]), .EC_reg_clear(ec_clr[0]), .write_commit(wc[0]),
    .mem_read_write(rw[0]), .mem_bus_out(bus_o[0]), .halted(hl[0]), .busy(bs[0])
  );

  mem_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_store(mem_store), .mem_load(mem_load),
    .mem_store_commit(mem_store_commit), .store_upper(store_upper),
    .is_branch_ex(is_branch_ex), .fetch_is_halt(fetch_is_halt),
    .commit_is_halt(commit_is_halt), .resume(resume),
    .pc_enable(pc_en[1]), .FE_reg_enable(fe_en[1]), .FE_reg_clear(fe_clr[1]),
    .EC_reg_enable(ec_en[1]), .EC_reg_clear(ec_clr[1]), .write_commit(wc[1]),
    .mem_read_write(rw[1]), .mem_bus_out(bus_o[1]), .halted(hl[1]), .busy(bs[1])
  );

  mem_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_store(mem_store), .mem_load(mem_load),
    .mem_store_commit(mem_store_commit), .store_upper(store_upper),
    .is_branch_ex(is_branch_ex), .fetch_is_halt(fetch_is_halt),
    .commit_is_halt(commit_is_halt), .resume(resume),
    .pc_enable(pc_en[2]), .FE_reg_enable(fe_en[2]), .FE_reg_clear(fe_clr[2]),
    .EC_reg_enable(ec_en[2]), .EC_reg_clear(ec_clr[2]), .write_commit(wc[2]),
    .mem_read_write(rw[2]), .mem_bus_out(bus_o[2]), .halted(hl[2]), .busy(bs[2])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs of instance i for the current inputs; fills the n_* arrays.
  // ctl = {pc_en, fe_en, fe_clr, ec_en, ec_clr, wc, rw, halted, busy}
  task automatic model_eval(input int i, output logic [8:0] ctl, output logic [AW-1:0] bus);
    logic pe, fe, fc, ee, ec, w, r, h, b, fin;
    int   k;
    pe = 0; fe = 0; fc = 0; ee = 0; ec = 0; w = 0; r = 1; h = 0; b = 0; fin = 0;
    bus = '0;
    k   = kind[i];
    n_mode[i] = mode[i]; n_rem[i] = rem[i]; n_kind[i] = kind[i];
    n_lbus[i] = lbus[i]; n_lrw[i] = lrw[i];
    if (!rst_n) begin
      n_mode[i] = MRun; n_rem[i] = 0;
    end else if (mode[i] == MHalt) begin
      h = 1; w = 1;
      if (resume) n_mode[i] = MRun;
    end else if (rem[i] > 0) begin
      b = 1; bus = lbus[i]; r = lrw[i];
      fin = (rem[i] == 1);
      n_rem[i] = rem[i] - 1;
    end else if (commit_is_halt) begin
      w = 1; n_mode[i] = MHalt;
    end else begin
      if (mem_store_commit) begin
        k = KStc; bus = {{(AW-DW-1){1'b0}}, store_upper, mem_write_data}; r = 0;
      end else if (mem_store || mem_load) begin
        k = KExm; bus = mem_address; r = !mem_store;
      end else if (is_branch_ex) begin
        k = KBr;
      end else begin
        k = KFet; bus = pc; r = 1;
      end
      if (k == KBr) begin
        fc = 1; ee = 1;
      end else if (WAITS[i] == 0) begin
        fin = 1;
      end else begin
        n_rem[i] = WAITS[i]; n_kind[i] = k; n_lbus[i] = bus; n_lrw[i] = r;
      end
    end
    if (fin) begin
      if (k == KStc) begin
        w = 1; ec = 1;
      end else if (k == KExm) begin
        fc = 1; ee = 1;
      end else begin
        fe = 1; ee = 1; pe = !fetch_is_halt;
      end
    end
    ctl = {pe, fe, fc, ee, ec, w, r, h, b};
  endtask

  // One clock: compare all instances before the edge, advance the model at the edge.
  task automatic step();
    logic [8:0]    ectl;
    logic [AW-1:0] ebus;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      model_eval(i, ectl, ebus);
      check_val($sformatf("ctl[w%0d]", WAITS[i]),
                {pc_en[i], fe_en[i], fe_clr[i], ec_en[i], ec_clr[i], wc[i], rw[i], hl[i], bs[i]},
                32'(ectl));
      check_val($sformatf("bus[w%0d]", WAITS[i]), 32'(bus_o[i]), 32'(ebus));
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      mode[i] = n_mode[i]; rem[i] = n_rem[i]; kind[i] = n_kind[i];
      lbus[i] = n_lbus[i]; lrw[i] = n_lrw[i];
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_store = 0; mem_load = 0; mem_store_commit = 0; store_upper = 0;
    is_branch_ex = 0; fetch_is_halt = 0; commit_is_halt = 0; resume = 0;
  endtask

  // Run idle cycles until instance i (per the model) is back in RUN with nothing held.
  task automatic wait_idle(input int i);
    int n = 0;
    idle_inputs();
    while ((rem[i] != 0 || mode[i] != MRun) && n < 10) begin
      step();
      n++;
    end
    check_val("wait_idle", 32'(rem[i] == 0 && mode[i] == MRun), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      mode[i] = MRun; rem[i] = 0; kind[i] = KFet; lbus[i] = '0; lrw[i] = 0;
    end
    rst_n = 0; pc = 10'h155; mem_address = '0; mem_write_data = '0;
    idle_inputs();
    @(posedge clk); #1;
    #1;
    check_val("reset_bus", 32'(bus_o[0]), 32'h0);
    check_val("reset_rw", 32'(rw[0]), 32'h1);
    step();
    step();

    // Plain fetch of 0x155; fetch_is_halt drops pc_enable for one cycle.
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      fetch_is_halt = (c == 3);
      #1;
      check_val("fetch_bus", 32'(bus_o[0]), 32'h155);
      check_val("fetch_pc_en", 32'(pc_en[0]), 32'(c != 3));
      step();
    end

    // Store commit on the 2-wait instance; data change mid-hold must not reach the bus.
    wait_idle(1);
    mem_store_commit = 1; mem_write_data = 6'h2A; store_upper = 1;
    #1;
    check_val("stc_bus_c1", 32'(bus_o[1]), 32'h06A);
    check_val("stc_wc_c1", 32'(wc[1]), 32'h0);
    step();
    mem_write_data = 6'h15; mem_store_commit = 0;
    #1;
    check_val("stc_bus_c2", 32'(bus_o[1]), 32'h06A);
    check_val("stc_busy_c2", 32'(bs[1]), 32'h1);
    step();
    #1;
    check_val("stc_wc_c3", 32'(wc[1]), 32'h1);
    check_val("stc_ecclr_c3", 32'(ec_clr[1]), 32'h1);
    step();

    // Store commit and load together: store goes first, then the load.
    wait_idle(1);
    mem_store_commit = 1; mem_load = 1; mem_address = 10'h3FF; mem_write_data = 6'h2A;
    for (int c = 0; c < 3; c++) step();
    mem_store_commit = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val("ld_bus", 32'(bus_o[1]), 32'h3FF);
      check_val("ld_rw", 32'(rw[1]), 32'h1);
      step();
    end
    mem_load = 0;

    // Branch on the 3-wait instance completes in one cycle.
    wait_idle(2);
    is_branch_ex = 1;
    #1;
    check_val("br_ctl", {pc_en[2], fe_clr[2], ec_en[2], bs[2]}, 32'b0110);
    check_val("br_bus", 32'(bus_o[2]), 32'h0);
    step();
    is_branch_ex = 0;

    // Halt: hold commit_is_halt until every instance has entered HALTED.
    begin
      int n = 0;
      commit_is_halt = 1;
      while ((mode[0] != MHalt || mode[1] != MHalt || mode[2] != MHalt) && n < 10) begin
        step();
        n++;
      end
      check_val("halt_all", 32'(mode[0] == MHalt && mode[1] == MHalt && mode[2] == MHalt), 32'd1);
      commit_is_halt = 0;
    end
    for (int c = 0; c < 20; c++) begin
      #1;
      check_val("halt_held", 32'(hl), 32'h7);
      step();
    end
    resume = 1;
    step();
    resume = 0;
    #1;
    check_val("resume_run", 32'(hl), 32'h0);
    check_val("resume_fetch", 32'(bus_o[0]), 32'h155);
    step();

    // Reset in the second HOLD cycle of a 3-wait store.
    wait_idle(2);
    mem_store_commit = 1;
    step();
    mem_store_commit = 0;
    step();
    rst_n = 0;
    #1;
    check_val("rst_hold_busy", 32'(bs[2]), 32'h0);
    check_val("rst_hold_wc", 32'(wc[2]), 32'h0);
    step();
    rst_n = 1;
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      pc               = AW'($urandom);
      mem_address      = AW'($urandom);
      mem_write_data   = DW'($urandom);
      store_upper      = 1'($urandom);
      mem_store_commit = ($urandom_range(0, 5) == 0);
      mem_store        = ($urandom_range(0, 5) == 0);
      mem_load         = ($urandom_range(0, 5) == 0);
      is_branch_ex     = ($urandom_range(0, 5) == 0);
      fetch_is_halt    = ($urandom_range(0, 7) == 0);
      commit_is_halt   = ($urandom_range(0, 39) == 0);
      resume           = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_sequencer.md
Name: mem_bus_sequencer

Overview:
- Sequential successor to the pipeline's combinational stall/bus controller for the 3-stage (fetch / execute / commit) core.
- Owns the shared address/data bus and generates the pc, FE and EC pipeline-register enables and clears.
- Adds parametrised bus/data widths and a configurable number of memory wait states per bus transaction. The bus address and data are latched while a transaction is held.
- Adds a registered HALTED state that is left only on an explicit resume.

Parameters:
ADDR_W, 10, bus/address width; must be at least DATA_W+1
DATA_W, 6, store data width; bus bit DATA_W carries the store-upper flag
WAIT_CYCLES, 0, extra cycles each bus transaction is held; 0 gives single-cycle legacy timing

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pc  in  ADDR_W  fetch address
mem_address  in  ADDR_W  load/store address from the execute stage
mem_write_data  in  DATA_W  store data from the commit stage
mem_store  in  1  execute-stage instruction is a store
mem_load  in  1  execute-stage instruction is a load
mem_store_commit  in  1  commit-stage instruction is a store
store_upper  in  1  commit-stage store is STOREU
is_branch_ex  in  1  execute-stage instruction is a branch
fetch_is_halt  in  1  instruction word returning from memory is HALT
commit_is_halt  in  1  commit-stage instruction is HALT
resume  in  1  single-cycle pulse that leaves HALTED
pc_enable, FE_reg_enable, FE_reg_clear, EC_reg_enable, EC_reg_clear  out  1 each  pipeline control
write_commit  out  1  bus write strobe / halt signature
mem_read_write  out  1  1 = read, 0 = write
mem_bus_out  out  ADDR_W  bus address/data
halted  out  1  high in HALTED
busy  out  1  high in HOLD

Behaviour:
- States: RUN, HOLD, HALTED. Registers: state; cnt (width $clog2(WAIT_CYCLES+1), minimum 1); kind (STC/EXM/FET); latched bus value; latched read/write bit.
- Reset (rst_n low, asynchronous): state RUN, cnt 0, latches 0.
  - While rst_n is low, outputs are forced: all enables and clears 0, write_commit 0, mem_read_write 1, mem_bus_out 0, halted 0, busy 0.
- Output defaults, applied in every state unless overridden: all enables and clears 0, write_commit 0, mem_read_write 1, mem_bus_out 0.
- RUN priority, highest first: commit_is_halt > mem_store_commit (STC) > mem_store|mem_load (EXM) > is_branch_ex (BR) > fetch (FET).
- commit_is_halt in RUN:
  - Same cycle: mem_read_write 1, write_commit 1, all enables 0.
  - Next state HALTED.
- BR never uses the bus and always completes in one cycle in RUN: FE_reg_clear 1, EC_reg_enable 1, pc_enable 0, bus 0.
- Bus value per kind:
  - STC: bus[DATA_W-1:0] = mem_write_data, bus[DATA_W] = store_upper, other bits 0, rw 0.
  - EXM: bus = mem_address, rw = ~mem_store.
  - FET: bus = pc, rw 1.
- Final-cycle outputs per kind (bus and rw driven as above):
  - STC: write_commit 1, EC_reg_clear 1, pc/FE/EC enables 0.
  - EXM: FE_reg_clear 1, EC_reg_enable 1, pc_enable 0.
  - FET: FE_reg_enable 1, EC_reg_enable 1, pc_enable = ~fetch_is_halt, sampled in the final cycle.
- Transaction length is 1+WAIT_CYCLES cycles.
  - WAIT_CYCLES=0: the RUN cycle is the final cycle; state stays RUN.
  - WAIT_CYCLES>0, first cycle (in RUN): drive the live bus value and rw; write_commit 0; all enables and clears 0. Latch kind, bus and rw; load cnt = WAIT_CYCLES; go to HOLD.
  - HOLD: drive the latched bus and rw; all enables and clears 0; busy 1.
    - cnt==1: final cycle; emit that kind's final outputs; next state RUN.
    - Otherwise decrement cnt.
    - Input changes to pc, mem_address or mem_write_data during HOLD do not change mem_bus_out.
    - commit_is_halt and all new requests are ignored in HOLD; they are re-evaluated in RUN.
- HALTED: halted 1, mem_read_write 1, write_commit 1, all enables and clears 0, bus 0.
  - resume=1 → RUN next cycle.
  - Without resume, remain in HALTED indefinitely.
- Reset asserted in any state (including mid-HOLD) aborts the transaction immediately. No partial write_commit is produced.

Test Plan:
1. WAIT_CYCLES=0, pc=0x155, no requests → every cycle: bus 0x155, rw 1, pc/FE/EC enables 1, busy 0; fetch_is_halt=1 → pc_enable 0 that cycle only.
2. WAIT_CYCLES=2, mem_store_commit, data 0x2A, store_upper 1 → bus 0x06A, rw 0 for 3 cycles.
   - busy 1 in cycles 2-3; write_commit and EC_reg_clear 1 only in cycle 3.
   - Changing mem_write_data to 0x15 in cycle 2 leaves bus at 0x06A.
3. WAIT_CYCLES=2, mem_store_commit and mem_load (addr 0x3FF) asserted together → STC first (3 cycles).
   - Then the load runs 3 cycles: bus 0x3FF, rw 1; final cycle FE_reg_clear 1, EC_reg_enable 1, pc_enable 0.
4. WAIT_CYCLES=3, is_branch_ex only → single cycle: FE_reg_clear 1, EC_reg_enable 1, pc_enable 0, bus 0, busy 0.
5. commit_is_halt in RUN → same cycle rw 1 and write_commit 1; halted 1 from next cycle and held 20 cycles; resume pulse → next cycle RUN fetch of pc, halted 0.
6. WAIT_CYCLES=3, rst_n low in the second HOLD cycle → outputs immediately at reset values, busy 0; after release → RUN fetch, no write_commit pulse.
